mul_arb: RTL
============

MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive requester-0 grants while requester 1 waits; used only in fixed-priority mode, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  packed complex operands: [7:4] signed real, [3:0] signed imaginary.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same widths and meanings for requester 1.
REQ-008 rsp_valid  output  1  result register holds a valid product.
REQ-009 rsp_ready  input  1  consumer takes the result this cycle.
REQ-010 rsp_data  output  16  [15:8] signed real, [7:0] signed imaginary product.
REQ-011 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-012 busy  output  1  high while rsp_valid is high.

Function
REQ-013 The block shall contain one shared complex multiplier: real = ar*br - ai*bi and imag = ar*bi + ai*br, computed at full precision and truncated to 8 bits each, two's-complement wrap (example: (-8-8i)*(-8-8i) = 0x0080).
REQ-014 Two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 accept_ok = EMPTY, or FULL with rsp_ready=1 in the same cycle (drain and refill in one cycle).
REQ-016 At most one of req0_ready and req1_ready shall be high in any cycle; readyN = accept_ok & reqN_valid & grant==N.
REQ-017 When only one requester is valid, it shall be granted.
REQ-018 Handshake: a transfer occurs when reqN_valid & reqN_ready. On the next edge, rsp_data = product, rsp_id = N and the state becomes FULL. Latency is one cycle.
REQ-019 FULL with rsp_ready=1 and no new transfer shall go to EMPTY. FULL with rsp_ready=0 shall hold rsp_data and rsp_id stable.
REQ-020 Requesters shall hold valid and operands stable until ready. The block does not sample operands while ready is low.
REQ-021 Simultaneous valid requests: arbitration follows REQ-026/REQ-027.
REQ-022 busy = rsp_valid.

Reset
REQ-023 While rst=1 at a clock edge: rsp_valid=0, rsp_data=0, rsp_id=0, both ready=0, state=EMPTY, priority pointer=requester 0, streak counter=0.
REQ-024 Reset asserted mid-operation shall discard any held result without emitting it. Requests pending during reset are not accepted.
REQ-025 The first accept is possible in the cycle after rst deasserts.

Configuration
REQ-026 With MUL_ARB_RR_EN defined: round-robin arbitration. The pointer starts at 0. After each transfer the pointer shall point to the other requester. On a tie, the requester at the pointer wins.
REQ-027 Without MUL_ARB_RR_EN: fixed priority to requester 0, with a 4-bit streak counter.
- The counter increments on each requester-0 transfer while req1_valid=1.
- The counter clears on any requester-1 transfer, or when req1_valid=0.
- When the counter equals STARVE_LIMIT, requester 1 shall win the next tie.

Verification
REQ-028 Reset, then req0 issues 0x11 * 0x01, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=0xFF01, rsp_id=0. The next cycle rsp_valid=0.
REQ-029 req1 issues 0x37 * 0x81 -> rsp_data=0xE1CB, rsp_id=1. Also drive 0x88 * 0x88 -> rsp_data=0x0080.
REQ-030 Hold rsp_ready=0 with result FULL for 5 cycles while both requesters are valid -> both ready stay 0 and rsp_data is stable. Raise rsp_ready -> drain and accept occur in the same cycle.
REQ-031 Both requesters valid continuously, rsp_ready=1, MUL_ARB_RR_EN defined -> rsp_id alternates 0,1,0,1.
REQ-032 Same stimulus with MUL_ARB_RR_EN undefined and STARVE_LIMIT=4 -> rsp_id sequence 0,0,0,0,1,0,0,0,0,1.
REQ-033 Assert rst for 1 cycle while FULL -> rsp_valid=0 next cycle, the held result is never emitted, and the pointer/streak counter are reset.

Source files
------------

// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - two-requester arbiter in front of one shared 4b complex multiplier
// Define MUL_ARB_RR_EN for round-robin arbitration; default is fixed priority with starvation guard.
module mul_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        accept_ok, pick1, grant1, xfer;
  logic [7:0]  op_a, op_b;
  logic signed [7:0] ar, ai, br, bi, re_prod, im_prod;

`ifdef MUL_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign pick1 = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = ~grant1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  logic [3:0] streak_q, streak_d;

  assign pick1 = (streak_q == 4'(STARVE_LIMIT));

  // Counts requester-0 wins while requester 1 is kept waiting.
  always_comb begin
    streak_d = streak_q;
    if (req1_ready || !req1_valid) streak_d = 4'd0;
    else if (req0_ready)           streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= 4'd0;
    else     streak_q <= streak_d;
  end
`endif

  always_comb begin
    accept_ok  = ~rsp_valid_q | rsp_ready;
    grant1     = (req0_valid & req1_valid) ? pick1 : req1_valid;
    req0_ready = ~rst & accept_ok & req0_valid & ~grant1;
    req1_ready = ~rst & accept_ok & req1_valid & grant1;
    xfer       = req0_ready | req1_ready;

    op_a = grant1 ? req1_a : req0_a;
    op_b = grant1 ? req1_b : req0_b;
    ar   = {{4{op_a[7]}}, op_a[7:4]};
    ai   = {{4{op_a[3]}}, op_a[3:0]};
    br   = {{4{op_b[7]}}, op_b[7:4]};
    bi   = {{4{op_b[3]}}, op_b[3:0]};
    // Mod-256 arithmetic yields exactly the truncated full-precision result.
    re_prod = ar * br - ai * bi;
    im_prod = ar * bi + ai * br;

    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = {re_prod, im_prod};
      rsp_id_d    = grant1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
      rsp_id_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid_q;

endmodule
